msk_unmask: RTL and testbench

Share-recombination (unmasking) block for masked datapaths. It accepts a `count`-bit value encoded as `d` Boolean shares per bit, registers the sharing, and recombines it serially, one share per cycle, into a plain value. Serial recombination ensures no single combinational cone ever XORs all shares of a bit together. It sits at the output boundary of a masked core, after the last `MSKreg` stage, and hands unmasked results to unprotected logic through a valid/ready handshake.

---
 rtl/msk_unmask.sv | 110 +++++++++++
 tb/tb_msk_unmask.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/msk_unmask.sv
// Serial share-recombination (unmasking) block: captures a d-share sharing and XORs one share per cycle.
// Optional build macro MSK_UNMASK_CLEAR_EN scrubs share_reg and acc once they have been consumed.
module msk_unmask #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [count*d-1:0]   in_sh,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [count-1:0]     out_data
);

    localparam int unsigned idx_w = (d > 1) ? $clog2(d) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [count*d-1:0]    share_reg;
    logic [count*d-1:0]    shifted;
    logic [count-1:0]      acc;
    logic [count-1:0]      sel;
    logic [idx_w-1:0]      idx;
    logic                  last_idx;

    // NOTE: every register, including the sharing store, is reset so no stale share survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= next_state;
        end
    end

    assign last_idx = (idx == idx_w'(d - 1));

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ACC;
            end
            ACC: begin
                if (last_idx) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Share idx of every bit lands at a fixed stride after shifting by idx.
    always_comb begin
        shifted = share_reg >> idx;
        sel     = '0;
        for (int i = 0; i < int'(count); i++) begin
            sel[i] = shifted[i*d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_reg <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        share_reg <= in_sh;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                ACC: begin
                    acc <= acc ^ sel;
                    if (d > 1) idx <= idx + idx_w'(1);
`ifdef MSK_UNMASK_CLEAR_EN
                    if (last_idx) share_reg <= '0;
`endif
                end
                DONE: begin
`ifdef MSK_UNMASK_CLEAR_EN
                    if (out_ready) acc <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // The accumulator is only exposed once recombination is complete.
    assign out_data = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_msk_unmask.sv
// Directed self-checking bench for msk_unmask across several d/count configurations.
module tb_msk_unmask;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // A: d=2 count=4
    logic       a_valid, a_ready, a_ovalid, a_ordy;
    logic [7:0] a_sh;
    logic [3:0] a_data;
    // B: d=1 count=8
    logic       b_valid, b_ready, b_ovalid, b_ordy;
    logic [7:0] b_sh;
    logic [7:0] b_data;
    // C: d=3 count=1
    logic       c_valid, c_ready, c_ovalid, c_ordy;
    logic [2:0] c_sh;
    logic [0:0] c_data;
    // D: d=4 count=4
    logic        e_valid, e_ready, e_ovalid, e_ordy;
    logic [15:0] e_sh;
    logic [3:0]  e_data;

    msk_unmask #(.d(2), .count(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_sh(a_sh),
        .out_valid(a_ovalid), .out_ready(a_ordy), .out_data(a_data));
    msk_unmask #(.d(1), .count(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_sh(b_sh),
        .out_valid(b_ovalid), .out_ready(b_ordy), .out_data(b_data));
    msk_unmask #(.d(3), .count(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_sh(c_sh),
        .out_valid(c_ovalid), .out_ready(c_ordy), .out_data(c_data));
    msk_unmask #(.d(4), .count(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(e_valid), .in_ready(e_ready), .in_sh(e_sh),
        .out_valid(e_ovalid), .out_ready(e_ordy), .out_data(e_data));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        a_valid = 0; a_sh = '0; a_ordy = 0;
        b_valid = 0; b_sh = '0; b_ordy = 0;
        c_valid = 0; c_sh = '0; c_ordy = 0;
        e_valid = 0; e_sh = '0; e_ordy = 0;
        step(2);
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_in_ready", 16'(a_ready), 16'h1);
        check("rst_out_valid", 16'(a_ovalid), 16'h0);
        check("rst_out_data", 16'(a_data), 16'h0);

        // Basic d=2 count=4: shares 0x6 ^ 0xC = 0xA
        a_valid = 1; a_sh = 8'hB4; a_ordy = 1;
        step();
        a_valid = 0;
        check("basic_acc0_ready", 16'(a_ready), 16'h0);
        check("basic_acc0_valid", 16'(a_ovalid), 16'h0);
        check("basic_acc0_data", 16'(a_data), 16'h0);
        step();
        check("basic_acc1_valid", 16'(a_ovalid), 16'h0);
        check("basic_acc1_data", 16'(a_data), 16'h0);
        step();
        check("basic_done_valid", 16'(a_ovalid), 16'h1);
        check("basic_done_data", 16'(a_data), 16'hA);
        check("basic_done_ready", 16'(a_ready), 16'h0);
`ifdef MSK_UNMASK_CLEAR_EN
        check("clr_share_reg_done", 16'(dut_a.share_reg), 16'h0);
`else
        check("ret_share_reg_done", 16'(dut_a.share_reg), 16'hB4);
`endif
        step();
        check("basic_post_ready", 16'(a_ready), 16'h1);
        check("basic_post_valid", 16'(a_ovalid), 16'h0);
        check("basic_post_data", 16'(a_data), 16'h0);
`ifdef MSK_UNMASK_CLEAR_EN
        check("clr_acc_after_hs", 16'(dut_a.acc), 16'h0);
`else
        check("ret_acc_after_hs", 16'(dut_a.acc), 16'hA);
`endif

        // d=1 count=8: value passes through after one ACC cycle
        b_valid = 1; b_sh = 8'h5A; b_ordy = 1;
        step();
        b_valid = 0;
        check("d1_acc_valid", 16'(b_ovalid), 16'h0);
        step();
        check("d1_done_valid", 16'(b_ovalid), 16'h1);
        check("d1_done_data", 16'(b_data), 16'h5A);
        step();
        check("d1_post_ready", 16'(b_ready), 16'h1);

        // Backpressure d=3 count=1: 1^1^1 = 1, held for 5 cycles
        c_valid = 1; c_sh = 3'h7; c_ordy = 0;
        step();
        c_valid = 0;
        step(2);
        check("bp_acc_valid", 16'(c_ovalid), 16'h0);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_valid_%0d", k), 16'(c_ovalid), 16'h1);
            check($sformatf("bp_hold_data_%0d", k), 16'(c_data), 16'h1);
            check($sformatf("bp_hold_ready_%0d", k), 16'(c_ready), 16'h0);
            step();
        end
        c_ordy = 1;
        step();
        check("bp_release_ready", 16'(c_ready), 16'h1);
        check("bp_release_valid", 16'(c_ovalid), 16'h0);
        c_ordy = 0;

        // Busy rejection on d=2: only the first sharing (bit0 = 1^0) counts
        a_valid = 1; a_sh = 8'h01; a_ordy = 0;
        step();
        a_sh = 8'hFF;
        check("busy_acc_ready", 16'(a_ready), 16'h0);
        step();
        a_sh = 8'hAA;
        step();
        a_sh = 8'h55;
        check("busy_done_data", 16'(a_data), 16'h1);
        check("busy_done_ready", 16'(a_ready), 16'h0);
        step();
        a_sh = 8'hC3;
        check("busy_hold_data", 16'(a_data), 16'h1);
        a_valid = 0; a_ordy = 1;
        step();
        check("busy_post_valid", 16'(a_ovalid), 16'h0);
        check("busy_post_ready", 16'(a_ready), 16'h1);
        step();
        check("busy_idle_stays", 16'(a_ovalid), 16'h0);

        // Reset mid-ACC on d=4
        e_valid = 1; e_sh = 16'h0001; e_ordy = 1;
        step();
        e_valid = 0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 16'(e_ovalid), 16'h0);
        check("mid_rst_data", 16'(e_data), 16'h0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_rst_ready", 16'(e_ready), 16'h1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("mid_rst_no_stale_%0d", k), 16'(e_ovalid), 16'h0);
            step();
        end

        // Fresh transaction on d=4 after reset: bit1 shares 1,0,0,0
        e_valid = 1; e_sh = 16'h0010; e_ordy = 0;
        step();
        e_valid = 0;
        step(3);
        check("d4_acc_last_valid", 16'(e_ovalid), 16'h0);
        step();
        check("d4_done_valid", 16'(e_ovalid), 16'h1);
        check("d4_done_data", 16'(e_data), 16'h2);
        e_ordy = 1;
        step();
        check("d4_post_ready", 16'(e_ready), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
